icache_nway: RTL and testbench

- Parametrised N-way set-associative, multi-word-block instruction cache; successor to the current direct-mapped, one-word-block icache.
- Sits between the fetch stage (imem request side) and the memory controller (instruction port, iwait handshake).
- Adds associativity, multi-word line fill, round-robin replacement and a flush/invalidate operation.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/icache_victim_sel.sv | 55 +++++
 rtl/icache_nway.sv | 169 ++++++++++++++++
 tb/tb_icache_nway.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types; instruction-cache state encoding and defaults.
// Revision : 1.0 - initial n-way icache types
// ============================================================================
package cpu_types_pkg;

   typedef enum logic [0:0] {
      IC_IDLE = 1'b0,
      IC_FILL = 1'b1
   } icache_state_t;

   localparam int ICACHE_WAYS  = 2;
   localparam int ICACHE_IDX_W = 3;
   localparam int ICACHE_BLK_W = 1;
   localparam int IBYT_W       = 2;

   // Index width for an n-entry selector, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module   : icache_victim_sel
// Brief    : Replacement way choice: lowest invalid way, else per-set round robin.
// Revision : 1.0 - initial release
// ============================================================================
module icache_victim_sel #(
   parameter int WAYS  = 2,
   parameter int IDX_W = 3,
   parameter int WAY_W = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [IDX_W-1:0] i_sel_idx,
   input  logic [WAYS-1:0]  i_valid_set,
   input  logic             i_rr_adv,
   input  logic [IDX_W-1:0] i_adv_idx,
   output logic [WAY_W-1:0] o_victim,
   output logic             o_from_rr
);

   logic [WAY_W-1:0] w_rr_ptr;

   generate
      if (WAYS > 1) begin : g_rr
         logic [WAY_W-1:0] r_rr [2**IDX_W];

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               for (int s = 0; s < 2**IDX_W; s++) r_rr[s] <= '0;
            end else if (i_rr_adv) begin
               r_rr[i_adv_idx] <= r_rr[i_adv_idx] + 1'b1;
            end
         end

         assign w_rr_ptr = r_rr[i_sel_idx];
      end else begin : g_no_rr
         assign w_rr_ptr = '0;
      end
   endgenerate

   // Descending scan so the lowest invalid way is the final winner.
   always_comb begin
      o_victim  = w_rr_ptr;
      o_from_rr = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!i_valid_set[w]) begin
            o_victim  = WAY_W'(w);
            o_from_rr = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway
// Brief    : N-way set-associative multi-word-line icache with flush.
//            Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module icache_nway
   import cpu_types_pkg::*;
#(
   parameter int WAYS  = ICACHE_WAYS,
   parameter int IDX_W = ICACHE_IDX_W,
   parameter int BLK_W = ICACHE_BLK_W
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        iflush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,output logic [31:0] hit_count
   ,output logic [31:0] miss_count
`endif
);

   localparam int TAG_W = 32 - IDX_W - BLK_W - IBYT_W;
   localparam int SETS  = 2**IDX_W;
   localparam int WORDS = 2**BLK_W;
   localparam int WAY_W = idx_width(WAYS);
   localparam int CNT_W = idx_width(WORDS);

   icache_state_t    r_state, w_state_nxt;
   logic [WAYS-1:0]  r_valid [SETS];
   logic [TAG_W-1:0] r_tag   [SETS][WAYS];
   logic [31:0]      r_data  [SETS][WAYS][WORDS];
   logic [TAG_W-1:0] r_ltag;
   logic [IDX_W-1:0] r_lidx;
   logic [WAY_W-1:0] r_victim;
   logic             r_from_rr;
   logic [CNT_W-1:0] r_wordcnt;

   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_idx;
   logic [CNT_W-1:0] w_off;
   logic             w_hit;
   logic [WAY_W-1:0] w_hit_way;
   logic [WAY_W-1:0] w_victim;
   logic             w_from_rr;
   logic             w_miss, w_accept, w_last, w_done;
   logic             w_unused_byte;

   assign w_tag         = imemaddr[31 -: TAG_W];
   assign w_idx         = imemaddr[IBYT_W + BLK_W +: IDX_W];
   assign w_unused_byte = ^imemaddr[IBYT_W-1:0];

   generate
      if (BLK_W > 0) begin : g_off
         assign w_off = imemaddr[IBYT_W +: CNT_W];
      end else begin : g_no_off
         assign w_off = '0;
      end
   endgenerate

   // Descending scan lets the lowest matching way win.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   assign ihit     = (r_state == IC_IDLE) && imemREN && w_hit && !iflush;
   assign imemload = ihit ? r_data[w_idx][w_hit_way][w_off] : '0;
   assign iREN     = (r_state == IC_FILL);
   assign iaddr    = {r_ltag, r_lidx, {(BLK_W + IBYT_W){1'b0}}}
                   | (32'(r_wordcnt) << IBYT_W);

   assign w_miss   = (r_state == IC_IDLE) && imemREN && !w_hit && !iflush;
   assign w_accept = (r_state == IC_FILL) && !iwait;
   assign w_last   = w_accept && (r_wordcnt == CNT_W'(WORDS - 1));
   assign w_done   = w_last && !iflush;

   icache_victim_sel #(
      .WAYS  (WAYS),
      .IDX_W (IDX_W),
      .WAY_W (WAY_W)
   ) u_victim_sel (
      .CLK         (CLK),
      .nRST        (nRST),
      .i_sel_idx   (w_idx),
      .i_valid_set (r_valid[w_idx]),
      .i_rr_adv    (w_done && r_from_rr),
      .i_adv_idx   (r_lidx),
      .o_victim    (w_victim),
      .o_from_rr   (w_from_rr)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= IC_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IC_IDLE: if (w_miss)           w_state_nxt = IC_FILL;
         IC_FILL: if (iflush || w_last) w_state_nxt = IC_IDLE;
         default:                       w_state_nxt = IC_IDLE;
      endcase
   end

   // Victim line is invalidated at miss time so an aborted fill leaves no stale hit.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
         r_ltag    <= '0;
         r_lidx    <= '0;
         r_victim  <= '0;
         r_from_rr <= 1'b0;
         r_wordcnt <= '0;
      end else if (iflush) begin
         for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end else if (w_miss) begin
         r_ltag                   <= w_tag;
         r_lidx                   <= w_idx;
         r_victim                 <= w_victim;
         r_from_rr                <= w_from_rr;
         r_wordcnt                <= '0;
         r_valid[w_idx][w_victim] <= 1'b0;
      end else if (w_accept) begin
         if (w_last) r_valid[r_lidx][r_victim] <= 1'b1;
         else        r_wordcnt <= r_wordcnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_accept) r_data[r_lidx][r_victim][r_wordcnt] <= iload;
      if (w_done)   r_tag[r_lidx][r_victim]             <= r_ltag;
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hit_count, r_miss_count;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (ihit)   r_hit_count  <= r_hit_count + 32'd1;
         if (w_miss) r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_nway
// Brief    : Randomised scoreboard bench for icache_nway against a line-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_nway;

   localparam int WAYS   = 2;
   localparam int IDX_W  = 3;
   localparam int BLK_W  = 1;
   localparam int SETS   = 2**IDX_W;
   localparam int WORDS  = 2**BLK_W;
   localparam int LINE_B = WORDS * 4;

   typedef struct {
      logic [31:0] data;
      bit          hit;
      int          issue;
      int          acc0;
      int          nacc;
   } exp_t;

   logic        CLK, nRST, imemREN, iflush, ihit, iREN, iwait;
   logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   icache_nway #(.WAYS(WAYS), .IDX_W(IDX_W), .BLK_W(BLK_W)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .iflush(iflush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
      .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   int checks = 0, failures = 0;
   int cyc = 0, acc_cnt = 0, last_acc = 0, done_cnt = 0, issued = 0;
   int fixed_lat = 2;
   int mhit = 0, mmiss = 0;
   bit in_reset_test = 0, prev_flush = 0;
   exp_t        sb[$];
   logic [31:0] fillq[$];
   exp_t        mon_e;
   logic [31:0] mon_a;
   int          mon_cyc;

   bit          mv  [SETS][WAYS];
   int unsigned mt  [SETS][WAYS];
   int          mrr [SETS];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      if (wa == 32'h40) return 32'h11111111;
      if (wa == 32'h44) return 32'h22222222;
      return (wa * 32'h9E3779B1) ^ 32'hC0FFEE00;
   endfunction

   function automatic int unsigned set_of(input logic [31:0] a);
      return (a / LINE_B) % SETS;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return a / (LINE_B * SETS);
   endfunction

   function automatic bit model_lookup(input logic [31:0] a);
      for (int w = 0; w < WAYS; w++)
         if (mv[set_of(a)][w] && mt[set_of(a)][w] == tag_of(a)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_fill(input logic [31:0] a);
      int v = -1;
      int s = int'(set_of(a));
      for (int w = 0; w < WAYS; w++) if (!mv[s][w] && v < 0) v = w;
      if (v < 0) begin
         v = mrr[s];
         mrr[s] = (mrr[s] + 1) % WAYS;
      end
      mv[s][v] = 1'b1;
      mt[s][v] = tag_of(a);
      mmiss++;
      for (int k = 0; k < WORDS; k++) fillq.push_back((a & ~32'(LINE_B - 1)) + 32'(4 * k));
   endtask

   task automatic model_flush();
      for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
   endtask

   task automatic model_reset();
      model_flush();
      for (int s = 0; s < SETS; s++) mrr[s] = 0;
      mhit  = 0;
      mmiss = 0;
   endtask

   task automatic finish_up();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt < issued && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      if (done_cnt < issued) begin
         checks++; failures++;
         $display("FAIL request_timeout: completed=%0d required=%0d", done_cnt, issued);
         finish_up();
      end
   endtask

   task automatic push_exp(input logic [31:0] a, input bit h, input int nacc);
      exp_t e;
      e.data  = mem_word(a);
      e.hit   = h;
      e.issue = cyc;
      e.acc0  = acc_cnt;
      e.nacc  = nacc;
      sb.push_back(e);
      issued++;
      mhit++;
   endtask

   task automatic fetch(input logic [31:0] a);
      bit h = model_lookup(a);
      if (!h) model_fill(a);
      push_exp(a, h, h ? 0 : WORDS);
      imemREN  = 1'b1;
      imemaddr = a;
      wait_done();
      imemREN  = 1'b0;
   endtask

   task automatic flush_idle(input logic [31:0] a);
      iflush   = 1'b1;
      imemREN  = 1'b1;
      imemaddr = a;
      model_flush();
      @(posedge CLK); #1;
      iflush  = 1'b0;
      imemREN = 1'b0;
   endtask

   // The aborted fill accepts one word, then the refetch refills the whole line.
   task automatic flush_mid_fill(input logic [31:0] a);
      int n = 0;
      int a0;
      model_flush();
      fillq.push_back(a & ~32'(LINE_B - 1));
      a0 = acc_cnt;
      model_fill(a);
      mmiss++;
      push_exp(a, 1'b0, WORDS + 1);
      imemREN  = 1'b1;
      imemaddr = a;
      while (acc_cnt < a0 + 1 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      iflush = 1'b1;
      @(posedge CLK); #1;
      iflush = 1'b0;
      wait_done();
      imemREN = 1'b0;
   endtask

   // Memory: holds iwait for `lat` cycles, then presents one word.
   initial begin
      int wcnt;
      int lat;
      wcnt  = 0;
      lat   = 2;
      iwait = 1'b1;
      iload = '0;
      forever begin
         @(posedge CLK); #1;
         if (iREN) begin
            if (wcnt >= lat) begin
               iwait = 1'b0;
               iload = mem_word(iaddr);
               wcnt  = 0;
               lat   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
            end else begin
               iwait = 1'b1;
               wcnt++;
            end
         end else begin
            iwait = 1'b1;
            wcnt  = 0;
         end
      end
   end

   always @(negedge CLK) begin
      if (nRST && !in_reset_test) begin
         if (prev_flush) begin
            checks++;
            if (iREN !== 1'b0) begin
               failures++;
               $display("FAIL iren_after_flush: iREN=%b required 0", iREN);
            end
         end
         if (iREN && !iwait && !iflush) begin
            checks++;
            if (fillq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_fill: iaddr=%h required no request", iaddr);
            end else begin
               mon_a = fillq.pop_front();
               if (iaddr !== mon_a) begin
                  failures++;
                  $display("FAIL fill_addr: iaddr=%h required %h", iaddr, mon_a);
               end
            end
            acc_cnt++;
            last_acc = cyc;
         end
         if (ihit) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL spurious_hit: imemaddr=%h imemload=%h required no hit", imemaddr, imemload);
            end else begin
               mon_e = sb.pop_front();
               if (imemload !== mon_e.data) begin
                  failures++;
                  $display("FAIL imemload: addr=%h got %h required %h", imemaddr, imemload, mon_e.data);
               end
               checks++;
               if (acc_cnt - mon_e.acc0 != mon_e.nacc) begin
                  failures++;
                  $display("FAIL fill_words: addr=%h got %0d required %0d", imemaddr, acc_cnt - mon_e.acc0, mon_e.nacc);
               end
               checks++;
               mon_cyc = mon_e.hit ? mon_e.issue : last_acc + 1;
               if (cyc != mon_cyc) begin
                  failures++;
                  $display("FAIL hit_latency: addr=%h hit at cycle %0d required %0d", imemaddr, cyc, mon_cyc);
               end
               done_cnt++;
            end
         end
      end
      prev_flush = iflush && nRST;
   end

   initial begin
      nRST = 1'b0; imemREN = 1'b0; iflush = 1'b0; imemaddr = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      checks += 4;
      if (ihit !== 1'b0)      begin failures++; $display("FAIL reset_ihit: got %b required 0", ihit); end
      if (iREN !== 1'b0)      begin failures++; $display("FAIL reset_iren: got %b required 0", iREN); end
      if (iaddr !== 32'h0)    begin failures++; $display("FAIL reset_iaddr: got %h required 0", iaddr); end
      if (imemload !== 32'h0) begin failures++; $display("FAIL reset_imemload: got %h required 0", imemload); end
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;

      // Cold miss at two wait cycles per word, then a zero-latency hit on word 1.
      fetch(32'h40);
      fetch(32'h44);
      fixed_lat = -1;

      // Three tags in one set: the third evicts the first.
      fetch(32'h440); fetch(32'h840); fetch(32'h440); fetch(32'h040);

      // Round-robin wrap on set 5, then refetch all four tags.
      for (int t = 0; t < 4; t++) fetch(32'((32 + t) * 64 + 5 * 8));
      for (int t = 3; t >= 0; t--) fetch(32'((32 + t) * 64 + 5 * 8 + 4));

      // Flush while idle after three valid lines.
      fetch(32'h1008); fetch(32'h1010); fetch(32'h1018);
      flush_idle(32'h1008);
      fetch(32'h1008); fetch(32'h1010); fetch(32'h1018);

      flush_mid_fill(32'h2004);
      fetch(32'h2000);

      // Asynchronous reset while a fill is outstanding.
      fetch(32'h100);
      in_reset_test = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h3000;
      repeat (2) begin @(posedge CLK); #1; end
      checks++;
      if (iREN !== 1'b1) begin failures++; $display("FAIL fill_started: iREN=%b required 1", iREN); end
      #2 nRST = 1'b0;
      #1;
      checks += 2;
      if (iREN !== 1'b0) begin failures++; $display("FAIL reset_mid_fill_iren: got %b required 0", iREN); end
      if (ihit !== 1'b0) begin failures++; $display("FAIL reset_mid_fill_ihit: got %b required 0", ihit); end
      imemREN = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      model_reset();
      @(posedge CLK); #1;
      in_reset_test = 1'b0;
      fetch(32'h100);

      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 4)) << 6) | (32'($urandom_range(0, 3)) << 3)
           | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) flush_idle(a);
         else                            fetch(a);
      end

      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (sb.size() != 0 || fillq.size() != 0) begin
         failures++;
         $display("FAIL leftover: pending hits=%0d fills=%0d required 0 0", sb.size(), fillq.size());
      end
`ifdef ICACHE_STATS_EN
      checks += 2;
      if (hit_count !== 32'(mhit)) begin
         failures++; $display("FAIL hit_count: got %0d required %0d", hit_count, mhit);
      end
      if (miss_count !== 32'(mmiss)) begin
         failures++; $display("FAIL miss_count: got %0d required %0d", miss_count, mmiss);
      end
`endif
      finish_up();
   end

   initial begin
      #2000000;
      checks++; failures++;
      $display("FAIL global_timeout: simulation time limit reached");
      finish_up();
   end

endmodule
`default_nettype wire
